// File: rtl/key_cmd_scheduler.sv
// Debounced pushbutton front end for the 2048 engine: synchronise, filter,
// arbitrate simultaneous presses and queue move commands behind valid/ready.
module key_cmd_scheduler #(
    parameter int SAMPLE_DIV_W = 16,
    parameter int STABLE_CNT   = 2,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] key_n,
    input  logic       restart_sw,
    output logic       cmd_valid,
    output logic [2:0] cmd_code,
    input  logic       cmd_ready,
    output logic       overflow,
    output logic [7:0] drop_cnt
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [2:0] LAST = 3'(STABLE_CNT - 1);

    logic [SAMPLE_DIV_W-1:0] div;
    logic                    tick;
    logic [4:0]              sync1;
    logic [4:0]              sync2;
    logic [4:0]              stable;
    logic [2:0]              cnt [5];
    logic [4:0]              rise;

    logic                    win;
    logic                    win_restart;
    logic [2:0]              win_code;
    logic [2:0]              n_ev;
    logic [2:0]              losers;

    logic [2:0]              mem [FIFO_DEPTH];
    logic [AW-1:0]           rd;
    logic [AW-1:0]           wr;
    logic [AW:0]             count;
    logic                    full;
    logic                    pop;
    logic                    push;
    logic                    full_drop;
    logic [8:0]              drop_sum;

    assign tick = &div;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            div <= '0;
        end else begin
            div <= div + 1'b1;
        end
    end

    // Bit order: [4]=restart [3]=up [2]=down [1]=left [0]=right, pressed=1
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= {restart_sw, ~key_n};
            sync2 <= sync1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stable <= '0;
            for (int i = 0; i < 5; i++) cnt[i] <= '0;
        end else if (tick) begin
            for (int i = 0; i < 5; i++) begin
                if (sync2[i] == stable[i]) begin
                    cnt[i] <= '0;
                end else if (cnt[i] == LAST) begin
                    stable[i] <= sync2[i];
                    cnt[i]    <= '0;
                end else begin
                    cnt[i] <= cnt[i] + 3'd1;
                end
            end
        end
    end

    always_comb begin
        rise = '0;
        for (int i = 0; i < 5; i++) begin
            rise[i] = tick && sync2[i] && !stable[i] && (cnt[i] == LAST);
        end
    end

    always_comb begin
        win_code    = 3'd0;
        win_restart = 1'b0;
        priority case (1'b1)
            rise[4]: begin
                win_code    = 3'd5;
                win_restart = 1'b1;
            end
            rise[3]: win_code = 3'd1;
            rise[2]: win_code = 3'd2;
            rise[1]: win_code = 3'd3;
            rise[0]: win_code = 3'd4;
            default: win_code = 3'd0;
        endcase
    end

    assign win    = |rise;
    assign n_ev   = 3'($countones(rise));
    assign losers = n_ev - {2'b00, win};

    assign full      = (count == (AW+1)'(FIFO_DEPTH));
    assign cmd_valid = (count != '0);
    assign cmd_code  = cmd_valid ? mem[rd] : 3'd0;
    assign pop       = cmd_valid & cmd_ready;
    assign push      = win & !win_restart & (!full | pop);
    assign full_drop = win & !win_restart & full & !pop;
    assign drop_sum  = {1'b0, drop_cnt} + 9'(losers) + 9'(full_drop);

    // A restart flushes the queue and becomes its only entry; flush beats pop.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd    <= '0;
            wr    <= '0;
            count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
        end else if (win_restart) begin
            rd     <= '0;
            wr     <= AW'(1);
            count  <= (AW+1)'(1);
            mem[0] <= 3'd5;
        end else begin
            if (push) mem[wr] <= win_code;
            wr    <= wr + AW'(push);
            rd    <= rd + AW'(pop);
            count <= count + (AW+1)'(push) - (AW+1)'(pop);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            overflow <= 1'b0;
            drop_cnt <= '0;
        end else begin
            if (full_drop) overflow <= 1'b1;
            drop_cnt <= drop_sum[8] ? 8'hFF : drop_sum[7:0];
        end
    end

endmodule

// File: tb/tb_key_cmd_scheduler.sv
// Directed bench for key_cmd_scheduler: tick every 16 clk, two-sample
// debounce, four-entry queue.
`timescale 1ns/1ps
module tb_key_cmd_scheduler;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [3:0] key_n = 4'hF;
    logic       restart_sw = 1'b0;
    logic       cmd_valid;
    logic [2:0] cmd_code;
    logic       cmd_ready = 1'b0;
    logic       overflow;
    logic [7:0] drop_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int vcnt  = 0;
    int v0    = 0;

    key_cmd_scheduler #(
        .SAMPLE_DIV_W(4),
        .STABLE_CNT  (2),
        .FIFO_DEPTH  (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_n     (key_n),
        .restart_sw(restart_sw),
        .cmd_valid (cmd_valid),
        .cmd_code  (cmd_code),
        .cmd_ready (cmd_ready),
        .overflow  (overflow),
        .drop_cnt  (drop_cnt)
    );

    initial forever #5 clk = ~clk;

    // Edge count since reset release; every 16th edge is a sample tick.
    always @(posedge clk or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    always @(negedge clk) begin
        if (cmd_valid) vcnt <= vcnt + 1;
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic to_tick();
        do step(); while (cyc % 16 != 0);
    endtask

    task automatic ticks(input int n);
        repeat (n) to_tick();
    endtask

    task automatic do_reset();
        rst        = 1'b0;
        key_n      = 4'hF;
        restart_sw = 1'b0;
        cmd_ready  = 1'b0;
        #17;
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic outs(input string tag, input logic v, input logic [2:0] c,
                        input logic o, input logic [7:0] d);
        chk({tag, "_valid"}, 16'(cmd_valid), 16'(v));
        chk({tag, "_code"},  16'(cmd_code),  16'(c));
        chk({tag, "_ovf"},   16'(overflow),  16'(o));
        chk({tag, "_drop"},  16'(drop_cnt),  16'(d));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // 1: idle after reset
        #3;
        outs("rst_hold", 1'b0, 3'd0, 1'b0, 8'd0);
        do_reset();
        v0 = vcnt;
        repeat (200) step();
        chk("idle_pulses", 16'(vcnt - v0), 16'd0);
        outs("idle", 1'b0, 3'd0, 1'b0, 8'd0);

        // 2: held up gives one command right after the second tick
        do_reset();
        cmd_ready = 1'b1;
        key_n     = 4'b0111;
        v0        = vcnt;
        to_tick();
        chk("up_t1_valid", 16'(cmd_valid), 16'd0);
        to_tick();
        chk("up_t2_valid", 16'(cmd_valid), 16'd1);
        chk("up_t2_code",  16'(cmd_code),  16'd1);
        step();
        chk("up_popped", 16'(cmd_valid), 16'd0);
        ticks(3);
        key_n = 4'hF;
        ticks(3);
        chk("up_pulses", 16'(vcnt - v0), 16'd1);
        chk("up_drop",   16'(drop_cnt),  16'd0);

        // 3: bouncing left never qualifies
        do_reset();
        cmd_ready = 1'b1;
        v0        = vcnt;
        for (int i = 0; i < 10; i++) begin
            key_n[1] = ~key_n[1];
            to_tick();
        end
        ticks(3);
        chk("bounce_pulses", 16'(vcnt - v0), 16'd0);
        chk("bounce_drop",   16'(drop_cnt),  16'd0);
        chk("bounce_ovf",    16'(overflow),  16'd0);

        // 4: up and left together, up wins
        do_reset();
        cmd_ready = 1'b1;
        key_n     = 4'b0101;
        ticks(2);
        outs("arb", 1'b1, 3'd1, 1'b0, 8'd1);
        step();
        chk("arb_popped", 16'(cmd_valid), 16'd0);
        ticks(3);
        chk("arb_held_drop", 16'(drop_cnt), 16'd1);

        // 5: fill queue with right, fifth press overflows, then drain
        do_reset();
        for (int i = 0; i < 5; i++) begin
            key_n = 4'b1110;
            ticks(2);
            if (i == 3) chk("fill4_ovf", 16'(overflow), 16'd0);
            key_n = 4'hF;
            ticks(2);
        end
        outs("full", 1'b1, 3'd4, 1'b1, 8'd1);
        cmd_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_valid", 16'(cmd_valid), 16'd1);
            chk("drain_code",  16'(cmd_code),  16'd4);
            step();
        end
        outs("drained", 1'b0, 3'd0, 1'b1, 8'd1);

        // 6: restart flushes queue; reset while keys held
        do_reset();
        for (int i = 0; i < 3; i++) begin
            key_n = 4'b1110;
            ticks(2);
            key_n = 4'hF;
            ticks(2);
        end
        chk("pre_restart_code", 16'(cmd_code), 16'd4);
        restart_sw = 1'b1;
        ticks(2);
        outs("restart", 1'b1, 3'd5, 1'b0, 8'd0);
        cmd_ready = 1'b1;
        step();
        chk("restart_sole", 16'(cmd_valid), 16'd0);
        cmd_ready = 1'b0;
        key_n     = 4'b0111;
        ticks(2);
        outs("queued_up", 1'b1, 3'd1, 1'b0, 8'd0);
        #3;
        rst = 1'b0;
        #1;
        outs("async_rst", 1'b0, 3'd0, 1'b0, 8'd0);
        @(negedge clk);
        rst = 1'b1;
        to_tick();
        chk("requal_t1_valid", 16'(cmd_valid), 16'd0);
        to_tick();
        outs("requal_t2", 1'b1, 3'd5, 1'b0, 8'd1);

        // 7: five-way presses, drop counter saturates
        do_reset();
        cmd_ready = 1'b1;
        for (int i = 0; i < 64; i++) begin
            key_n      = 4'h0;
            restart_sw = 1'b1;
            ticks(2);
            key_n      = 4'hF;
            restart_sw = 1'b0;
            ticks(2);
            if (i == 62) chk("sat_pre", 16'(drop_cnt), 16'd252);
        end
        chk("sat_drop", 16'(drop_cnt), 16'd255);
        chk("sat_ovf",  16'(overflow), 16'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
